ring_state_fsm: RTL and testbench

Parametrised N-state ring sequencer. It is the next generation of the fixed three-state input-driven stepper. Each cycle with `in` high advances the state by one position. Added over the fixed stepper:
- bidirectional stepping
- wrap or saturate end behaviour
- synchronous load
- illegal-state recovery with a sticky flag
- wrap pulse and lap counter

Used as a generic step/phase tracker inside control paths.

---
 rtl/ring_state_fsm.sv | 94 +++++++++
 tb/tb_ring_state_fsm.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ring_state_fsm.sv
// Parametrised N-state ring sequencer: steps up or down on `in`, with wrap or
// saturate at the ends, synchronous load, illegal-state recovery and a lap counter.
module ring_state_fsm #(
  parameter int NUM_STATES = 3,
  parameter int STATE_W    = 2,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in,
  input  logic               dir,
  input  logic               mode,
  input  logic               load,
  input  logic [STATE_W-1:0] load_state,
  output logic [STATE_W-1:0] state,
  output logic               wrap,
  output logic               at_first,
  output logic               at_last,
  output logic [CNT_W-1:0]   lap_count,
  output logic               illegal_seen
);

  localparam logic [STATE_W-1:0] FIRST = '0;
  localparam logic [STATE_W-1:0] LAST  = STATE_W'(NUM_STATES - 1);

  // One extra bit so the compare still works when NUM_STATES == 2**STATE_W.
  function automatic logic is_legal(input logic [STATE_W-1:0] v);
    return {1'b0, v} < (STATE_W + 1)'(NUM_STATES);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  logic [STATE_W-1:0] nxt_state;
  logic               wrap_ev;
  logic               ill_ev;

  always_comb begin
    nxt_state = state;
    wrap_ev   = 1'b0;
    ill_ev    = 1'b0;
    if (load) begin
      if (is_legal(load_state)) begin
        nxt_state = load_state;
      end else begin
        nxt_state = FIRST;
        ill_ev    = 1'b1;
      end
    end else if (!is_legal(state)) begin
      nxt_state = FIRST;
      ill_ev    = 1'b1;
    end else if (in) begin
      if (!dir) begin
        if (state == LAST) begin
          if (!mode) begin
            nxt_state = FIRST;
            wrap_ev   = 1'b1;
          end
        end else begin
          nxt_state = state + STATE_W'(1);
        end
      end else begin
        if (state == FIRST) begin
          if (!mode) begin
            nxt_state = LAST;
            wrap_ev   = 1'b1;
          end
        end else begin
          nxt_state = state - STATE_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FIRST;
      wrap         <= 1'b0;
      lap_count    <= '0;
      illegal_seen <= 1'b0;
    end else begin
      state <= nxt_state;
      wrap  <= wrap_ev;
      if (wrap_ev) lap_count <= sat_inc(lap_count);
      if (ill_ev) illegal_seen <= 1'b1;
    end
  end

  // Illegal encodings are neither first nor last because LAST is always legal.
  assign at_first = (state == FIRST);
  assign at_last  = (state == LAST);

endmodule

// File: tb/tb_ring_state_fsm.sv
// Directed bench for ring_state_fsm: a vector table on the default 3-state ring,
// plus hand sequences for illegal recovery, lap saturation and reset priority.
module tb_ring_state_fsm;

  logic clk = 1'b0;
  logic rst, in, dir, mode, load;
  logic [1:0] ls_a;
  logic [0:0] ls_b;
  logic [2:0] ls_c;

  logic [1:0] a_state; logic a_wrap, a_first, a_last, a_ill; logic [7:0] a_lap;
  logic [0:0] b_state; logic b_wrap, b_first, b_last, b_ill; logic [1:0] b_lap;
  logic [2:0] c_state; logic c_wrap, c_first, c_last, c_ill; logic [7:0] c_lap;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ring_state_fsm #(.NUM_STATES(3), .STATE_W(2), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .in(in), .dir(dir), .mode(mode), .load(load),
    .load_state(ls_a), .state(a_state), .wrap(a_wrap), .at_first(a_first),
    .at_last(a_last), .lap_count(a_lap), .illegal_seen(a_ill));

  ring_state_fsm #(.NUM_STATES(2), .STATE_W(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in(in), .dir(dir), .mode(mode), .load(load),
    .load_state(ls_b), .state(b_state), .wrap(b_wrap), .at_first(b_first),
    .at_last(b_last), .lap_count(b_lap), .illegal_seen(b_ill));

  ring_state_fsm #(.NUM_STATES(5), .STATE_W(3), .CNT_W(8)) dut_c (
    .clk(clk), .rst(rst), .in(in), .dir(dir), .mode(mode), .load(load),
    .load_state(ls_c), .state(c_state), .wrap(c_wrap), .at_first(c_first),
    .at_last(c_last), .lap_count(c_lap), .illegal_seen(c_ill));

  typedef struct {
    logic       rst, in, dir, mode, load;
    logic [1:0] ls;
    logic [1:0] s;
    logic       w;
    logic [7:0] lap;
    logic       ill;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic i, input logic d, input logic m,
                     input logic l, input logic [1:0] lsv, input logic [1:0] s,
                     input logic w, input logic [7:0] lap, input logic ill);
    vec_t v;
    v.rst = r; v.in = i; v.dir = d; v.mode = m; v.load = l; v.ls = lsv;
    v.s = s; v.w = w; v.lap = lap; v.ill = ill;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic i, input logic d, input logic m,
                       input logic l);
    rst = r; in = i; dir = d; mode = m; load = l;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int wraps;

  initial begin
    drive(1, 0, 0, 0, 0);
    ls_a = '0; ls_b = '0; ls_c = '0;

    //   rst in dir mode load ls   state wrap lap ill
    add(1, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0,   1, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0,   2, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0,   0, 1, 1, 0);
    add(0, 1, 0, 0, 0, 0,   1, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0,   2, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0,   0, 1, 2, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 2, 0);
    add(1, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0,   2, 1, 1, 0);
    add(0, 1, 1, 0, 0, 0,   1, 0, 1, 0);
    add(0, 1, 1, 0, 0, 0,   0, 0, 1, 0);
    add(0, 1, 1, 1, 0, 0,   0, 0, 1, 0);
    add(0, 1, 1, 1, 0, 0,   0, 0, 1, 0);
    add(0, 1, 0, 1, 1, 2,   2, 0, 1, 0);
    add(0, 1, 0, 1, 0, 0,   2, 0, 1, 0);
    add(0, 1, 0, 1, 0, 0,   2, 0, 1, 0);
    add(0, 1, 0, 1, 0, 0,   2, 0, 1, 0);
    add(0, 1, 0, 0, 1, 0,   0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0,   1, 0, 1, 0);
    add(0, 1, 0, 0, 1, 3,   0, 0, 1, 1);
    add(0, 1, 0, 0, 0, 0,   1, 0, 1, 1);
    add(1, 1, 0, 0, 0, 0,   0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0,   2, 1, 1, 0);
    add(0, 1, 0, 0, 0, 0,   0, 1, 2, 0);

    @(negedge clk);
    foreach (tbl[k]) begin
      drive(tbl[k].rst, tbl[k].in, tbl[k].dir, tbl[k].mode, tbl[k].load);
      ls_a = tbl[k].ls;
      tick();
      chk($sformatf("vec%0d state", k), 32'(a_state), 32'(tbl[k].s));
      chk($sformatf("vec%0d wrap", k), 32'(a_wrap), 32'(tbl[k].w));
      chk($sformatf("vec%0d lap", k), 32'(a_lap), 32'(tbl[k].lap));
      chk($sformatf("vec%0d illegal", k), 32'(a_ill), 32'(tbl[k].ill));
      chk($sformatf("vec%0d at_first", k), 32'(a_first), 32'(tbl[k].s == 2'd0));
      chk($sformatf("vec%0d at_last", k), 32'(a_last), 32'(tbl[k].s == 2'd2));
    end
    ls_a = '0;

    // Illegal state 3 on the 3-state ring, forced from outside.
    @(negedge clk);
    drive(0, 1, 0, 0, 0);
    force dut_a.state = 2'd3;
    #1;
    chk("ill forced state", 32'(a_state), 32'd3);
    chk("ill at_first", 32'(a_first), 32'd0);
    chk("ill at_last", 32'(a_last), 32'd0);
    @(posedge clk);
    @(negedge clk);
    release dut_a.state;
    drive(0, 0, 0, 0, 0);
    #1;
    chk("ill flag set", 32'(a_ill), 32'd1);
    chk("ill no wrap", 32'(a_wrap), 32'd0);
    tick();
    chk("ill recovered state", 32'(a_state), 32'd0);
    chk("ill lap kept", 32'(a_lap), 32'd2);
    drive(0, 1, 0, 0, 0);
    tick();
    chk("ill step after", 32'(a_state), 32'd1);
    chk("ill sticky", 32'(a_ill), 32'd1);
    drive(1, 0, 0, 0, 0);
    tick();
    chk("ill cleared by rst", 32'(a_ill), 32'd0);

    // Two-state ring with a 2-bit lap counter saturating at 3.
    drive(1, 0, 0, 0, 0);
    tick();
    chk("b reset lap", 32'(b_lap), 32'd0);
    wraps = 0;
    drive(0, 1, 0, 0, 0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (b_wrap) wraps++;
      chk($sformatf("b%0d state", k), 32'(b_state), 32'(k % 2));
      chk($sformatf("b%0d wrap", k), 32'(b_wrap), 32'(k % 2 == 0));
      chk($sformatf("b%0d lap", k), 32'(b_lap), 32'((k / 2 > 3) ? 3 : k / 2));
    end
    chk("b wrap total", 32'(wraps), 32'd6);

    // Five-state ring: reset mid-sequence and reset over load.
    drive(1, 0, 0, 0, 0);
    tick();
    drive(0, 1, 0, 0, 0);
    for (int k = 1; k <= 8; k++) tick();
    chk("c state 3", 32'(c_state), 32'd3);
    chk("c lap 1", 32'(c_lap), 32'd1);
    drive(1, 1, 0, 0, 0);
    tick();
    chk("c rst state", 32'(c_state), 32'd0);
    chk("c rst wrap", 32'(c_wrap), 32'd0);
    chk("c rst lap", 32'(c_lap), 32'd0);
    drive(0, 1, 0, 0, 0);
    for (int k = 1; k <= 4; k++) tick();
    chk("c state 4", 32'(c_state), 32'd4);
    chk("c at_last", 32'(c_last), 32'd1);
    drive(1, 1, 0, 0, 1);
    ls_c = 3'd4;
    tick();
    chk("c rst over load", 32'(c_state), 32'd0);
    chk("c rst over load wrap", 32'(c_wrap), 32'd0);
    drive(0, 0, 0, 0, 1);
    ls_c = 3'd5;
    tick();
    chk("c illegal load state", 32'(c_state), 32'd0);
    chk("c illegal load flag", 32'(c_ill), 32'd1);
    drive(0, 0, 0, 0, 0);
    ls_c = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
